imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Registered, handshaked successor to the combinational immediate generator. Sits between fetch and execute.
- Decodes the immediate for every RV32I/RV64I format, parametrised by XLEN. Also reports the format, an illegal-encoding flag and a precomputed PC-relative target.
- Provides a valid/ready interface with a 2-entry skid buffer, so backpressure never creates a combinational ready path.

Parameters:
- XLEN, 32, datapath width. Legal values are 32 and 64; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline kill
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_instr  input  32  instruction word
- in_pc  input  XLEN  instruction address
- out_valid  output  1  decoded result valid
- out_ready  input  1  consumer accepts the result
- out_imm  output  XLEN  decoded immediate
- out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
- out_pc  output  XLEN  pc passed through
- out_target  output  XLEN  pc+imm for B, J and AUIPC; 0 otherwise
- out_illegal  output  1  unsupported or illegal encoding

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=1, and out_imm, out_fmt, out_pc, out_target, out_illegal all 0. Both buffer entries are invalidated.
- Transfers: in on in_valid&in_ready; out on out_valid&out_ready.
- Latency: exactly 1 cycle from input accept to out_valid when empty. Decode logic sits before the main register.
- States:
  - EMPTY: in_ready=1, out_valid=0. On accept, go to ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept with no drain: the new word goes to the skid entry; go to FULL.
    - Accept and drain together: the new word replaces main; stay in ONE.
    - Drain only: go to EMPTY.
  - FULL: in_ready=0, out_valid=1. On drain, the skid entry moves to main; go to ONE.
- Ordering is strict FIFO. Outputs are stable while out_valid=1 and out_ready=0.
- flush: next cycle is EMPTY with out_valid=0. flush beats any simultaneous accept or drain; a word presented in the flush cycle is dropped.
- Decode by opcode:
  - I format: 0010011, 0000011, 1100111 (JALR).
    - Sign-extend instr[31:20] to XLEN.
    - OP-IMM shifts (funct3 001/101): imm = zero-extended shamt, instr[24:20] for XLEN=32, instr[25:20] for XLEN=64. instr[30] is ignored.
  - 0011011 (OP-IMM-32): I format when XLEN=64; illegal when XLEN=32. Shifts use a 5-bit shamt, and instr[25]=1 is illegal.
  - S format: 0100011.
  - B format: 1100011, bit0 = 0.
  - U format: 0110111 and 0010111 give {instr[31:12], 12'b0}, sign-extended to XLEN.
  - J format: 1101111.
  - Sign extension always uses instr[31].
  - 1110011 (SYSTEM): see the optional feature.
  - 0110011, 0111011 (R-type) and 0001111 (fence): fmt NONE, imm 0, not illegal. 0111011 is illegal when XLEN=32.
  - Any other opcode, instr[1:0]!=2'b11, or XLEN=32 shift with instr[25]=1: out_illegal=1, fmt NONE, imm 0, target 0.
- out_target is computed modulo 2^XLEN; wrap-around is silent.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- When defined, SYSTEM instructions decode as follows:
  - funct3 101/110/111: fmt Z, imm = zero-extended instr[19:15] (zimm).
  - funct3 001/010/011: fmt I, imm = zero-extended instr[31:20] (CSR address).
  - funct3 100: illegal.
  - funct3 000 (ECALL/EBREAK): fmt NONE, imm 0.
- When undefined, every SYSTEM opcode gives fmt NONE, imm 0, out_illegal=0, and fmt code 6 is never produced.

Test Plan:
- XLEN=32, out_ready=1, instr 0xFFF00093 (addi -1), pc 0x0: one cycle later out_valid=1, imm 0xFFFFFFFF, fmt 1, illegal 0.
- instr 0xFE000EE3 (beq -4), pc 0x100: imm 0xFFFFFFFC, fmt 3, target 0x000000FC.
- out_ready=0, three back-to-back valid words A,B,C: in_ready=0 after B is accepted and C is held at the input. Then raise out_ready: outputs A,B,C in order, each held stable while stalled.
- Buffer FULL, assert flush together with in_valid=1: next cycle out_valid=0, in_ready=1, and the word presented with flush never appears.
- instr 0x00000000: illegal=1, imm 0. XLEN=32 instr 0x02009093 (slli shamt 32): illegal=1. XLEN=64, same instr: imm 0x20, fmt 1.
- XLEN=64 instr 0x800000B7 (lui): imm 0xFFFFFFFF80000000.
- With IMM_GEN_ZICSR_EN defined, instr 0x3007D073 (csrrwi mstatus, zimm 15): fmt 6, imm 0xF. Without the macro, the same instr gives fmt 0, imm 0, illegal 0.
- Assert rst_n low mid-transfer with the buffer FULL: outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate decoder sitting between fetch
// and execute. Reports immediate, format, illegal flag and a PC-relative target
// behind a valid/ready handshake with a 2-entry skid buffer (main + skid).
// in_ready and out_valid come straight from the state register, so downstream
// backpressure never reaches in_ready combinationally.
// Optional feature macro: IMM_GEN_ZICSR_EN (decode SYSTEM/CSR immediates).
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG_32 = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t dec;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] shamt5;
  logic [XLEN-1:0] shamt6;
  logic            accept;
  logic            drain;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Every immediate shape is sign-extended from instr[31] by the signed size cast.
  assign imm_i  = XLEN'($signed(in_instr[31:20]));
  assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
  assign shamt5 = XLEN'(in_instr[24:20]);
  assign shamt6 = XLEN'(in_instr[25:20]);

  // Decode the incoming word; this sits in front of the main register.
  always_comb begin
    dec.imm     = '0;
    dec.fmt     = FMT_NONE;
    dec.pc      = in_pc;
    dec.target  = '0;
    dec.illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opcode)
        OP_IMM: begin
          if (is_shift) begin
            if (XLEN == 32 && in_instr[25]) begin
              dec.illegal = 1'b1;
            end else begin
              dec.fmt = FMT_I;
              dec.imm = (XLEN == 32) ? shamt5 : shamt6;
            end
          end else begin
            dec.fmt = FMT_I;
            dec.imm = imm_i;
          end
        end
        OP_LOAD, OP_JALR: begin
          dec.fmt = FMT_I;
          dec.imm = imm_i;
        end
        OP_IMM_32: begin
          if (XLEN == 32) begin
            dec.illegal = 1'b1;
          end else if (is_shift) begin
            if (in_instr[25]) begin
              dec.illegal = 1'b1;
            end else begin
              dec.fmt = FMT_I;
              dec.imm = shamt5;
            end
          end else begin
            dec.fmt = FMT_I;
            dec.imm = imm_i;
          end
        end
        OP_STORE: begin
          dec.fmt = FMT_S;
          dec.imm = imm_s;
        end
        OP_BRANCH: begin
          dec.fmt = FMT_B;
          dec.imm = imm_b;
        end
        OP_LUI, OP_AUIPC: begin
          dec.fmt = FMT_U;
          dec.imm = imm_u;
        end
        OP_JAL: begin
          dec.fmt = FMT_J;
          dec.imm = imm_j;
        end
        OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
          case (funct3)
            3'b101, 3'b110, 3'b111: begin
              dec.fmt = FMT_Z;
              dec.imm = XLEN'(in_instr[19:15]);
            end
            3'b001, 3'b010, 3'b011: begin
              dec.fmt = FMT_I;
              dec.imm = XLEN'(in_instr[31:20]);
            end
            3'b100:  dec.illegal = 1'b1;
            default: dec.fmt = FMT_NONE;
          endcase
`else
          dec.fmt = FMT_NONE;
`endif
        end
        OP_REG, OP_FENCE: begin
          dec.fmt = FMT_NONE;
        end
        OP_REG_32: begin
          dec.illegal = (XLEN == 32);
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    if (!dec.illegal && (dec.fmt == FMT_B || dec.fmt == FMT_J || opcode == OP_AUIPC)) begin
      dec.target = in_pc + dec.imm;
    end
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Skid-buffer state machine: flush wins over accept and drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= dec;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q <= dec;
            state  <= FULL;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_pc      = main_q.pc;
  assign out_target  = main_q.target;
  assign out_illegal = main_q.illegal;

endmodule
